score_digits_driver: RTL and testbench

SCORE_DIGITS_DRIVER -- requirements
Module: score_digits_driver

---
 rtl/score_digits_driver.sv | 164 ++++++++++++++++
 tb/tb_score_digits_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/score_digits_driver.sv
// Score renderer: double-dabble BCD conversion of a 10-bit score into a 3-digit on-screen field.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero hundreds/tens slots.
module score_digits_driver #(
  parameter logic [10:0] TOP_LEFT_X = 11'd20,
  parameter logic [10:0] TOP_LEFT_Y = 11'd20,
  parameter int unsigned DIGIT_W    = 16,
  parameter int unsigned DIGIT_H    = 32
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [9:0]  value,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [3:0]  digit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        busy,
  output logic        digitsValid
);

  localparam logic [10:0] DigW   = 11'(DIGIT_W);
  localparam logic [10:0] DigW2  = 11'(2 * DIGIT_W);
  localparam logic [10:0] FieldW = 11'(3 * DIGIT_W);
  localparam logic [10:0] DigH   = 11'(DIGIT_H);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e      state_q, state_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d, bcd_adj;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, units_q, units_d;
  logic        valid_q, valid_d;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Conversion FSM
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    units_d = units_q;
    valid_d = valid_q;
    bcd_adj = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};
    unique case (state_q)
      StIdle: begin
        if (startOfFrame) begin
          bin_d   = (value > 10'd999) ? 10'd999 : value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Top bit of the adjusted scratch is always 0 since the input is clamped to 999.
        {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = StCommit;
      end
      StCommit: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        units_d = bcd_q[3:0];
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      valid_q <= valid_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign digitsValid = valid_q;

  // Pixel path
  logic [10:0] rel_x, rel_y;
  logic        in_field;
  logic [3:0]  digit_d, digit_q;
  logic [10:0] off_x_d, off_x_q, off_y_d, off_y_q;
  logic        inside_d, inside_q;

  always_comb begin
    rel_x    = pixelX - TOP_LEFT_X;
    rel_y    = pixelY - TOP_LEFT_Y;
    in_field = (pixelX >= TOP_LEFT_X) && (rel_x < FieldW) &&
               (pixelY >= TOP_LEFT_Y) && (rel_y < DigH);
    digit_d  = '0;
    off_x_d  = '0;
    off_y_d  = '0;
    inside_d = 1'b0;
    if (in_field) begin
      off_y_d = rel_y;
      if (rel_x < DigW) begin
        digit_d = hund_q;
        off_x_d = rel_x;
`ifdef LEADING_ZERO_BLANK_EN
        inside_d = valid_q && (hund_q != 4'd0);
`else
        inside_d = valid_q;
`endif
      end else if (rel_x < DigW2) begin
        digit_d = tens_q;
        off_x_d = rel_x - DigW;
`ifdef LEADING_ZERO_BLANK_EN
        inside_d = valid_q && ((hund_q != 4'd0) || (tens_q != 4'd0));
`else
        inside_d = valid_q;
`endif
      end else begin
        digit_d  = units_q;
        off_x_d  = rel_x - DigW2;
        inside_d = valid_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit_q  <= '0;
      off_x_q  <= '0;
      off_y_q  <= '0;
      inside_q <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      inside_q <= inside_d;
    end
  end

  assign digit           = digit_q;
  assign offsetX         = off_x_q;
  assign offsetY         = off_y_q;
  assign InsideRectangle = inside_q;

endmodule

// File: tb/tb_score_digits_driver.sv
// Directed self-checking bench for score_digits_driver (default parameters).
module tb_score_digits_driver;

  localparam int TLX = 20;
  localparam int TLY = 20;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [9:0]  value;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [3:0]  digit;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        busy;
  logic        digitsValid;

  int n_checks = 0;
  int n_errors = 0;

  score_digits_driver dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .value           (value),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .digit           (digit),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .busy            (busy),
    .digitsValid     (digitsValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
  endtask

  // Pulse is driven just after edge N and sampled at edge N+1; returns just after N+1.
  task automatic start_conv(input int unsigned v);
    value        = 10'(v);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic check_pix(input string tag, input int d, input int ox, input int oy,
                           input int ins);
    check_eq({tag, "_digit"}, digit, d);
    check_eq({tag, "_offx"}, offsetX, ox);
    check_eq({tag, "_offy"}, offsetY, oy);
    check_eq({tag, "_inside"}, InsideRectangle, ins);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    value        = '0;
    pixelX       = 11'(TLX + 3);
    pixelY       = 11'(TLY + 3);
    repeat (3) tick();
    check_pix("rst", 0, 0, 0, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", digitsValid, 0);
    resetN = 1'b1;
    tick();

    // Field scan before any conversion
    for (int s = 0; s < 3; s++) begin
      drive_pixel(TLX + s * 16 + 3, TLY + 4);
      check_eq("idle_inside", InsideRectangle, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_valid", digitsValid, 0);
    end

    // 537: busy N+1..N+11, display at N+12
    start_conv(537);
    check_eq("busy_537", busy, 1);
    for (int i = 2; i <= 11; i++) begin
      tick();
      check_eq("busy_537", busy, 1);
    end
    tick();
    check_eq("busy_537_end", busy, 0);
    check_eq("valid_537", digitsValid, 1);
    drive_pixel(TLX + 20, TLY + 5);
    check_pix("p537_tens", 3, 4, 5, 1);
    drive_pixel(TLX + 2, TLY + 9);
    check_pix("p537_hund", 5, 2, 9, 1);
    drive_pixel(TLX + 33, TLY + 0);
    check_pix("p537_units", 7, 1, 0, 1);

    // 1023 clamps to 999; second pulse while busy is dropped
    pixelX = 11'(TLX + 20);
    pixelY = 11'(TLY + 5);
    start_conv(1023);
    repeat (2) tick();
    value        = 10'd1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    repeat (7) tick();
    check_eq("busy_1023_n11", busy, 1);
    check_eq("hold_digit_n11", digit, 3);
    tick();
    check_eq("busy_1023_n12", busy, 0);
    tick();
    check_eq("p1023_tens", digit, 9);
    repeat (3) tick();
    check_eq("no_queue_busy", busy, 0);
    drive_pixel(TLX + 1, TLY + 1);
    check_pix("p1023_hund", 9, 1, 1, 1);
    drive_pixel(TLX + 40, TLY + 1);
    check_pix("p1023_units", 9, 8, 1, 1);
    drive_pixel(TLX + 17, TLY + 1);
    check_eq("no_queue_tens", digit, 9);

    // 7: leading-zero handling
    start_conv(7);
    repeat (11) tick();
`ifdef LEADING_ZERO_BLANK_EN
    drive_pixel(TLX + 5, TLY + 6);
    check_pix("p7_hund", 0, 5, 6, 0);
    drive_pixel(TLX + 21, TLY + 6);
    check_pix("p7_tens", 0, 5, 6, 0);
`else
    drive_pixel(TLX + 5, TLY + 6);
    check_pix("p7_hund", 0, 5, 6, 1);
    drive_pixel(TLX + 21, TLY + 6);
    check_pix("p7_tens", 0, 5, 6, 1);
`endif
    drive_pixel(TLX + 37, TLY + 6);
    check_pix("p7_units", 7, 5, 6, 1);

    // Field boundaries
    drive_pixel(TLX - 1, TLY + 5);
    check_pix("left_edge", 0, 0, 0, 0);
    drive_pixel(TLX + 48, TLY + 5);
    check_pix("right_edge", 0, 0, 0, 0);
    drive_pixel(TLX + 10, TLY + 32);
    check_pix("bottom_edge", 0, 0, 0, 0);
    drive_pixel(TLX + 10, TLY - 1);
    check_pix("top_edge", 0, 0, 0, 0);
    drive_pixel(TLX + 47, TLY + 31);
    check_pix("last_pixel", 7, 15, 31, 1);

    // Reset mid-SHIFT aborts without commit
    pixelX = 11'(TLX + 40);
    pixelY = 11'(TLY + 3);
    start_conv(123);
    repeat (4) tick();
    check_eq("pre_rst_digit", digit, 7);
    resetN = 1'b0;
    #1;
    check_pix("mid_rst", 0, 0, 0, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", digitsValid, 0);
    tick();
    resetN = 1'b1;
    repeat (14) tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_valid", digitsValid, 0);
    check_eq("post_rst_inside", InsideRectangle, 0);
    check_eq("post_rst_digit", digit, 0);

    start_conv(42);
    repeat (11) tick();
    check_eq("valid_42", digitsValid, 1);
    drive_pixel(TLX + 16, TLY + 2);
    check_pix("p42_tens", 4, 0, 2, 1);
    drive_pixel(TLX + 32, TLY + 2);
    check_pix("p42_units", 2, 0, 2, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_errors);
    $finish;
  end

endmodule
